oehb_chain: RTL
===============

OEHB_CHAIN -- requirements
Module: oehb_chain

Interface
REQ-001 The block SHALL have parameter DATA_TYPE, default 32, meaning the payload width in bits (legal range 1 or more).
REQ-002 The block SHALL have parameter NUM_SLOTS, default 4, meaning the number of opaque buffer stages in series (legal range 1 or more).
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: reset, synchronous and active-high.
REQ-005 Port ins SHALL be an input, DATA_TYPE bits wide: input payload.
REQ-006 Port ins_valid SHALL be an input, 1 bit wide: input valid.
REQ-007 Port ins_ready SHALL be an output, 1 bit wide: input ready.
REQ-008 Port outs SHALL be an output, DATA_TYPE bits wide: output payload.
REQ-009 Port outs_valid SHALL be an output, 1 bit wide: output valid.
REQ-010 Port outs_ready SHALL be an input, 1 bit wide: output ready.
REQ-011 Port occupancy SHALL be an output, $clog2(NUM_SLOTS+1) bits wide, present only when OEHB_CHAIN_OCCUPANCY_EN is defined: count of slots currently holding a token.

Function
REQ-012 Slot i (i = 0..NUM_SLOTS-1) SHALL hold a registered valid bit v[i] and a registered data word d[i]. Slot 0 is fed from ins; slot NUM_SLOTS-1 drives outs and outs_valid.
REQ-013 Each slot's upstream ready SHALL be r[i] = !v[i] || r[i+1], with r[NUM_SLOTS] = outs_ready and ins_ready = r[0]. Ready is combinational end-to-end; valid and data are fully registered.
REQ-014 On each clock edge, when r[i] is 1, v[i] SHALL load the upstream valid (ins_valid for i=0, else v[i-1]). When r[i] is 0, v[i] SHALL hold.
REQ-015 d[i] SHALL load the upstream data only when r[i] and the upstream valid are both 1. Otherwise d[i] holds, so data is never overwritten by a bubble.
REQ-016 Latency SHALL be exactly NUM_SLOTS cycles from ins accept (ins_valid && ins_ready) to outs_valid, through an empty chain with outs_ready held at 1.
REQ-017 Sustained throughput SHALL be one token per cycle when ins_valid and outs_ready are held at 1.
REQ-018 Tokens SHALL leave in acceptance order, with no loss or duplication.
REQ-019 outs_valid, once asserted, SHALL stay asserted with outs stable until outs_ready is sampled 1.
REQ-020 Full chain (all v = 1) with outs_ready = 0 SHALL give ins_ready = 0. The same full chain with outs_ready = 1 SHALL give ins_ready = 1: simultaneous accept and emit in one cycle, all tokens advance.
REQ-021 Bubbles SHALL be absorbed: a stalled downstream slot still lets upstream slots with v = 0 fill.
REQ-022 outs and d[] SHALL not be considered meaningful while the corresponding valid is 0.

Reset
REQ-023 With rst = 1 at a clock edge, every v[i] SHALL clear to 0 and every d[i] to 0, regardless of ongoing transfers (tokens in flight are discarded).
REQ-024 After reset, the outputs SHALL be outs_valid = 0, outs = 0, ins_ready = 1, and occupancy = 0 when present.
REQ-025 A transfer presented in the same cycle that rst = 1 SHALL NOT be accepted into state.

Configuration
REQ-026 Macro OEHB_CHAIN_OCCUPANCY_EN controls the occupancy feature.
REQ-027 When OEHB_CHAIN_OCCUPANCY_EN is defined:
- occupancy SHALL be a registered counter: +1 on ins accept only, -1 on outs accept only, unchanged when both or neither occur.
- occupancy SHALL always equal popcount(v), never exceed NUM_SLOTS, and never underflow.
REQ-028 When OEHB_CHAIN_OCCUPANCY_EN is not defined, the occupancy port and counter SHALL be absent. The remaining ports and behaviour SHALL be identical in both builds.

Verification
REQ-029 Reset and latency: NUM_SLOTS=4, DATA_TYPE=8, single token 0xA5 after reset with outs_ready=1 -> outs_valid rises 4 cycles after accept with outs=0xA5; occupancy goes 1 then back to 0.
REQ-030 Streaming: tokens 0..99 continuous, outs_ready=1 -> 100 consecutive outputs in order, one per cycle after the 4-cycle fill, with no gaps.
REQ-031 Full/backpressure: outs_ready=0 while 6 tokens are offered -> exactly 4 accepted and ins_ready=0 afterwards; occupancy=4. Then raise outs_ready with ins_valid=1 -> simultaneous accept/emit, occupancy stays 4.
REQ-032 Random: random ins_valid/outs_ready at 50% each for 10k cycles -> scoreboard shows no loss, duplication or reordering; outs held stable under stall; occupancy == popcount(v) every cycle.
REQ-033 Mid-operation reset: 3 tokens in flight, rst pulsed for 1 cycle -> next cycle all valids 0, ins_ready=1, occupancy=0; in-flight tokens never appear at outs.
REQ-034 Corner parameters: NUM_SLOTS=1, DATA_TYPE=1 and NUM_SLOTS=1, DATA_TYPE=64 -> latency 1, full throughput; the run is repeated with the macro undefined and gives identical outs.

Source files
------------

// File: rtl/oehb_chain.sv
`default_nettype none
// ============================================================================
//  Module   : oehb_chain
//  Purpose  : A series chain of NUM_SLOTS opaque elastic half-buffers.
//             Each slot holds a registered valid bit and data word. Valid and
//             data are fully registered. Ready ripples combinationally from
//             outs_ready back to ins_ready.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_TYPE   payload width in bits (>= 1)
//    NUM_SLOTS   number of buffer stages in series (>= 1)
//  Ports
//    clk         clock; all state updates on its rising edge
//    rst         synchronous active-high reset
//    ins         input payload           [DATA_TYPE-1:0]
//    ins_valid   input valid
//    ins_ready   input ready
//    outs        output payload          [DATA_TYPE-1:0]
//    outs_valid  output valid
//    outs_ready  output ready
//    occupancy   number of slots holding a token [$clog2(NUM_SLOTS+1)-1:0]
//                (present only when OEHB_CHAIN_OCCUPANCY_EN is defined)
//  Build option
//    OEHB_CHAIN_OCCUPANCY_EN  define to add the occupancy port and counter
// ============================================================================
module oehb_chain #(
    parameter int DATA_TYPE = 32,
    parameter int NUM_SLOTS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] ins,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    output logic [DATA_TYPE-1:0] outs,
    output logic                 outs_valid,
    input  logic                 outs_ready
`ifdef OEHB_CHAIN_OCCUPANCY_EN
    ,
    output logic [$clog2(NUM_SLOTS+1)-1:0] occupancy
`endif
);

    // Slot state
    logic [NUM_SLOTS-1:0] v_q;
    logic [DATA_TYPE-1:0] d_q [NUM_SLOTS];

    // Per-slot upstream view and ready chain
    logic [NUM_SLOTS-1:0] w_up_v;
    logic [DATA_TYPE-1:0] w_up_d [NUM_SLOTS];
    logic [NUM_SLOTS:0]   w_rdy;

    always_comb begin
        w_up_v[0] = ins_valid;
        w_up_d[0] = ins;
        for (int i = 1; i < NUM_SLOTS; i++) begin
            w_up_v[i] = v_q[i-1];
            w_up_d[i] = d_q[i-1];
        end
    end

    // A slot can take a new word if it is empty or if its own word is leaving
    // this cycle. Evaluated from the output end back so ready can pass
    // through a full chain in one cycle when outs_ready is high.
    always_comb begin
        w_rdy[NUM_SLOTS] = outs_ready;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            w_rdy[i] = !v_q[i] || w_rdy[i+1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_rdy[i]) begin
                    v_q[i] <= w_up_v[i];
                end
                // Data moves only with a real token, so a bubble never
                // overwrites the last word held in the slot.
                if (w_rdy[i] && w_up_v[i]) begin
                    d_q[i] <= w_up_d[i];
                end
            end
        end
    end

    assign ins_ready  = w_rdy[0];
    assign outs_valid = v_q[NUM_SLOTS-1];
    assign outs       = d_q[NUM_SLOTS-1];

`ifdef OEHB_CHAIN_OCCUPANCY_EN
    localparam int OCC_W = $clog2(NUM_SLOTS + 1);
    localparam logic [OCC_W-1:0] c_occ_one = OCC_W'(1);

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             w_acc_in;
    logic             w_acc_out;

    assign w_acc_in  = ins_valid && w_rdy[0];
    assign w_acc_out = v_q[NUM_SLOTS-1] && outs_ready;

    // Simultaneous accept and emit leave the count unchanged.
    always_comb begin
        occ_d = occ_q;
        if (w_acc_in && !w_acc_out) begin
            occ_d = occ_q + c_occ_one;
        end else if (!w_acc_in && w_acc_out) begin
            occ_d = occ_q - c_occ_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule
`default_nettype wire
